// File: rtl/npc_ctrl.sv
// npc_ctrl -- next-PC selection with a one-entry redirect hold across stalls.
// Optional feature: define NPC_ERET_EN to let Eret/EPC redirect fetch.
// Without it, Eret and EPC are accepted on the ports but have no effect.
//
// state | meaning
// RUN   | no redirect held; fetch follows the live requests
// PEND  | one redirect held in pend_addr/pend_pri until the stall clears
module npc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCOut,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        ExcReq,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic        PCUpdate,
  output logic [31:0] PCIn,
  output logic        Pending
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_addr, pend_addr_nxt;
  logic [1:0]  pend_pri, pend_pri_nxt;
  logic [1:0]  req_pri;
  logic [31:0] req_addr;

`ifndef NPC_ERET_EN
  // Eret/EPC stay on the port list so both builds share one interface.
  logic eret_unused;
  assign eret_unused = ^{Eret, EPC};
`endif

  // Pick the highest-priority live request; later assignments win.
  always_comb begin
    req_pri  = 2'd0;
    req_addr = PCOut + 32'd4;
    if (BranchTaken) begin
      req_pri  = 2'd1;
      req_addr = BranchTarget;
    end
    if (Jump) begin
      req_pri  = 2'd1;
      req_addr = JumpTarget;
    end
`ifdef NPC_ERET_EN
    if (Eret) begin
      req_pri  = 2'd2;
      req_addr = EPC;
    end
`endif
    if (ExcReq) begin
      req_pri  = 2'd3;
      req_addr = EXC_PC;
    end
  end

  // Next-state and PC load decisions; exceptions bypass the stall entirely.
  always_comb begin
    state_nxt     = state;
    pend_addr_nxt = pend_addr;
    pend_pri_nxt  = pend_pri;
    PCUpdate      = 1'b0;
    PCIn          = req_addr;
    if (reset) begin
      PCIn = RESET_PC;
    end else if (ExcReq) begin
      PCUpdate     = 1'b1;
      PCIn         = EXC_PC;
      state_nxt    = RUN;
      pend_pri_nxt = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (!Stall) begin
            PCUpdate = 1'b1;
          end else if (req_pri != 2'd0) begin
            state_nxt     = PEND;
            pend_addr_nxt = req_addr;
            pend_pri_nxt  = req_pri;
          end
        end
        PEND: begin
          if (Stall) begin
            PCIn = pend_addr;
            if (req_pri > pend_pri) begin
              pend_addr_nxt = req_addr;
              pend_pri_nxt  = req_pri;
            end
          end else begin
            PCUpdate     = 1'b1;
            PCIn         = (req_pri > pend_pri) ? req_addr : pend_addr;
            state_nxt    = RUN;
            pend_pri_nxt = 2'd0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State and hold registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pend_addr <= RESET_PC;
      pend_pri  <= 2'd0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_addr_nxt;
      pend_pri  <= pend_pri_nxt;
    end
  end

  assign Pending = (state == PEND);

endmodule

// File: tb/tb_npc_ctrl.sv
// Testbench for npc_ctrl: directed scenarios then randomized traffic,
// all checked against a behavioural model of the redirect hold.
module tb_npc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] PCOut;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        ExcReq;
  logic        Eret;
  logic [31:0] EPC;
  logic        PCUpdate;
  logic [31:0] PCIn;
  logic        Pending;

  int errors = 0;
  int checks = 0;

  // model: a held redirect is just (valid, priority, address)
  bit          m_held;
  int          m_pri;
  logic [31:0] m_addr;

`ifdef NPC_ERET_EN
  localparam bit ERET_ON = 1'b1;
`else
  localparam bit ERET_ON = 1'b0;
`endif

  npc_ctrl dut (
    .clk(clk), .reset(reset), .PCOut(PCOut), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .ExcReq(ExcReq),
    .Eret(Eret), .EPC(EPC), .PCUpdate(PCUpdate), .PCIn(PCIn),
    .Pending(Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic rs, input logic st, input logic pco_sel,
                        input logic [31:0] pco,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic ex, input logic er, input logic [31:0] epc);
    reset = rs; Stall = st; PCOut = pco_sel ? pco : PCOut;
    BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
    ExcReq = ex; Eret = er; EPC = epc;
  endtask

  // Live request ranking from the priority rules.
  task automatic live_req(output int pri, output logic [31:0] addr);
    pri = 0; addr = PCOut + 32'd4;
    if (ExcReq) begin pri = 3; addr = 32'h0000_4180; end
    else if (Eret && ERET_ON) begin pri = 2; addr = EPC; end
    else if (Jump) begin pri = 1; addr = JumpTarget; end
    else if (BranchTaken) begin pri = 1; addr = BranchTarget; end
  endtask

  // Compare combinational outputs with the model for the current inputs.
  task automatic model_check();
    int          p;
    logic [31:0] a;
    live_req(p, a);
    if (reset) begin
      check("rst_upd", PCUpdate, 0);
      check("rst_pcin", PCIn, 32'h0000_3000);
    end else if (Stall && p != 3) begin
      check("stall_upd", PCUpdate, 0);
    end else begin
      check("upd", PCUpdate, 1);
      if (m_held && p <= m_pri) check("pcin_held", PCIn, m_addr);
      else check("pcin", PCIn, a);
    end
  endtask

  // Clock edge: advance the model, then check the registered Pending.
  task automatic tick();
    int          p;
    logic [31:0] a;
    live_req(p, a);
    @(posedge clk);
    if (reset || p == 3 || !Stall) m_held = 1'b0;
    else if (p > 0 && (!m_held || p > m_pri)) begin
      m_held = 1'b1; m_pri = p; m_addr = a;
    end
    #1;
    check("pending", Pending, m_held);
  endtask

  task automatic cyc(input logic rs, input logic st, input logic pco_sel,
                     input logic [31:0] pco,
                     input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt,
                     input logic ex, input logic er, input logic [31:0] epc);
    @(negedge clk);
    set_in(rs, st, pco_sel, pco, br, bt, jp, jt, ex, er, epc);
    #1;
    model_check();
  endtask

  initial begin
    m_held = 1'b0; m_pri = 0; m_addr = '0;
    PCOut = 32'h3000;
    set_in(1, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);

    // reset for two cycles, then plain sequential fetch
    repeat (2) begin
      cyc(1, 0, 1, 32'h3000, 0, 0, 0, 0, 1, 1, 32'h5);
      check("r31_rst_pcin", PCIn, 32'h3000);
      check("r31_rst_upd", PCUpdate, 0);
      tick();
    end
    cyc(0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
    check("r31_seq", PCIn, 32'h3004);
    check("r31_upd", PCUpdate, 1);
    tick();

    // branch held across a stall
    cyc(0, 1, 0, 0, 1, 32'h3100, 0, 0, 0, 0, 0);
    check("r32_upd0", PCUpdate, 0);
    tick();
    check("r32_pend", Pending, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("r32_rel", PCIn, 32'h3100);
    check("r32_upd1", PCUpdate, 1);
    tick();
    check("r32_clr", Pending, 0);

    // jump held, then Eret during the stall
    cyc(0, 1, 0, 0, 0, 0, 1, 32'h3200, 0, 0, 0);
    tick();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3050);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("r33_rel", PCIn, ERET_ON ? 32'h3050 : 32'h3200);
    tick();

    // exception breaks a stalled hold
    cyc(0, 1, 0, 0, 1, 32'h3100, 0, 0, 0, 0, 0);
    tick();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("r34_upd", PCUpdate, 1);
    check("r34_pcin", PCIn, 32'h4180);
    tick();
    check("r34_pend", Pending, 0);

    // wraparound and jump-over-branch tie break
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    check("r35_wrap", PCIn, 32'h0000_0000);
    tick();
    cyc(0, 0, 0, 0, 1, 32'h3300, 1, 32'h3403, 0, 0, 0);
    check("r35_jmp", PCIn, 32'h3403);
    tick();

    // reset while a redirect is held
    cyc(0, 1, 1, 32'h3000, 0, 0, 1, 32'h3600, 0, 0, 0);
    tick();
    check("r36_pend1", Pending, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("r36_pend0", Pending, 0);
    cyc(0, 0, 1, 32'h3010, 0, 0, 0, 0, 0, 0, 0);
    check("r36_seq", PCIn, 32'h3014);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 55,
          1'b1,
          ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom,
          $urandom_range(0, 99) < 25, $urandom,
          $urandom_range(0, 99) < 20, $urandom,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 12, $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
